hash_feedforward: RTL and testbench
===================================

# hash_feedforward

Parametrised successor to the SHA-256 hash assembly stage. It collects HASH_LENGTH compression-output words in any order and adds each to the matching word of the previous hash, modulo 2^WORD_WIDTH (feed-forward). It assembles the result into a flat hash vector and, optionally, streams the result back to memory one word per cycle. It sits between the compression round engine and the message/digest memory.

## Interface

- HASH_LENGTH, 8, number of words per hash (≥2)
- WORD_WIDTH, 32, bits per word
- ADDR_WIDTH, 8, write-back address width
- WRITE_BASE, 0, first write-back address
- BIT_REVERSE, 1, 1 = bit-reverse each incoming word (bit i → bit WORD_WIDTH-1-i) before the add; 0 = use it as-is
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin a new hash; accepted only in IDLE or DONE
- in_valid  input  1  in_index/in_data valid this cycle
- in_index  input  $clog2(HASH_LENGTH)  word slot
- in_data  input  WORD_WIDTH  working-variable word
- prev_hash_vector  input  HASH_LENGTH*WORD_WIDTH  previous hash; word k at [k*WORD_WIDTH +: WORD_WIDTH]; sampled at capture
- in_ready  output  1  high in COLLECT
- hash_vector  output  HASH_LENGTH*WORD_WIDTH  result; same word mapping
- hash_vector_complete  output  1  high in DONE
- index_error  output  1  sticky: out-of-range index seen this run
- wr_en  output  1  write-back strobe (HASH_WRITEBACK_EN only)
- wr_addr  output  ADDR_WIDTH  write-back address
- wr_data  output  WORD_WIDTH  write-back word

## Operation

- States: IDLE, COLLECT, WRITE (HASH_WRITEBACK_EN only), DONE.
- IDLE/DONE with start=1 → COLLECT. Clears hash_vector, the received mask, index_error and hash_vector_complete.
- COLLECT capture on in_valid:
  - word[in_index] ← prev_hash_vector word[in_index] + f(in_data), mod 2^WORD_WIDTH; carry discarded. f is bit reversal when BIT_REVERSE=1.
  - Mask bit in_index set.
- Duplicate index: overwrite with the new sum; the mask is unchanged.
- in_index ≥ HASH_LENGTH: word dropped; index_error ← 1.
- The edge that completes the mask moves to WRITE, or to DONE when the feature is compiled out.
- WRITE: counter k runs 0..HASH_LENGTH-1 with wr_en=1, wr_addr=WRITE_BASE+k (mod 2^ADDR_WIDTH) and wr_data=word k. After k=HASH_LENGTH-1 → DONE.
- DONE: hash_vector and complete hold until start or reset.
- start in COLLECT/WRITE: ignored. in_valid outside COLLECT: ignored.
- hash_vector is stable (never changes) in WRITE and DONE.

## Timing

- Reset: state IDLE; hash_vector=0, hash_vector_complete=0, index_error=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0. Reset mid-run aborts without write-back.
- in_ready is high from the cycle after start is accepted. One word is accepted per cycle and back-to-back words are allowed.
- Words captured on edge t are visible on hash_vector from cycle t+1.
- Without write-back: hash_vector_complete=1 in the cycle after the edge that captures the last missing word. Minimum start-to-complete is HASH_LENGTH+1 edges.
- With write-back:
  - wr_en is high for exactly HASH_LENGTH consecutive cycles, starting the cycle after the last capture.
  - hash_vector_complete rises the cycle after the final write.
- A simultaneous start and in_valid in DONE starts the new run; that in_valid is ignored.
- Restart from DONE clears hash_vector the cycle after start.

## Configuration

- HASH_WRITEBACK_EN defined: the WRITE state, the word counter and the wr_* ports are live.
- Undefined: no WRITE state; wr_en, wr_addr and wr_data are tied to 0; COLLECT goes straight to DONE.

## Test plan

- Defaults, prev words all 0x6a09e667, in_data=0x80000000 at indices 0..7 in order, BIT_REVERSE=1 → every word 0x6a09e668; complete high 9 edges after start.
- Indices 7..0 in reverse with prev=0xFFFFFFFF and data whose f() is 0x00000002 → every word 0x00000001, showing the carry is discarded.
- Index 3 sent twice (f()=5, then 9) with prev word 3 = 1 → word 3 = 0x0000000A; complete only after all 8 distinct indices.
- HASH_LENGTH=6 with index 7 injected → index_error=1, no word changed, run still completes.
- HASH_WRITEBACK_EN, WRITE_BASE=0xFC, ADDR_WIDTH=8 → wr_addr FC,FD,FE,FF,00,01,02,03 on 8 consecutive cycles; complete the cycle after.
- Reset asserted with 4 words collected → next cycle all outputs 0 and state IDLE; the following start gives a clean run.

Source files
------------

// File: rtl/hash_feedforward.sv
// hash_feedforward
//   Feed-forward stage after the compression rounds. Collects HASH_LENGTH
//   working-variable words in any order, adds each (optionally bit-reversed)
//   to the matching word of the previous hash mod 2^WORD_WIDTH, and presents
//   the result on a flat vector. With HASH_WRITEBACK_EN defined, the result is
//   also streamed out one word per cycle before completion is flagged.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 begin a new hash (honoured in IDLE / DONE only)
//   in_valid/in_index/in_data   one word per cycle while in_ready is high
//   prev_hash_vector      previous hash, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   in_ready              high while collecting
//   hash_vector           assembled result, same word mapping
//   hash_vector_complete  high in DONE
//   index_error           sticky flag: out-of-range index seen this run
//   wr_en/wr_addr/wr_data write-back stream (tied to 0 without the macro)
//
// Build option: `define HASH_WRITEBACK_EN enables the WRITE state and wr_* ports.

module hash_feedforward #(
    parameter int HASH_LENGTH = 8,
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WRITE_BASE  = 0,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              in_valid,
    input  logic [$clog2(HASH_LENGTH)-1:0]    in_index,
    input  logic [WORD_WIDTH-1:0]             in_data,
    input  logic [HASH_LENGTH*WORD_WIDTH-1:0] prev_hash_vector,
    output logic                              in_ready,
    output logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector,
    output logic                              hash_vector_complete,
    output logic                              index_error,
    output logic                              wr_en,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [WORD_WIDTH-1:0]             wr_data
);

    localparam int IDX_W = $clog2(HASH_LENGTH);

`ifdef HASH_WRITEBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
`endif

    state_t state, state_n;

    logic [HASH_LENGTH-1:0][WORD_WIDTH-1:0] words;
    logic [HASH_LENGTH-1:0][WORD_WIDTH-1:0] prev_w;
    logic [HASH_LENGTH-1:0]                 mask;
    logic [HASH_LENGTH-1:0]                 hit;
    logic [WORD_WIDTH-1:0]                  data_f;
    logic [WORD_WIDTH-1:0]                  sum;
    logic                                   in_range;
    logic                                   restart;
    logic                                   capture;
    logic                                   last_word;

    assign prev_w      = prev_hash_vector;
    assign hash_vector = words;

    generate
        if (BIT_REVERSE) begin : g_rev
            for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
                assign data_f[i] = in_data[WORD_WIDTH-1-i];
            end
        end else begin : g_thru
            assign data_f = in_data;
        end

        // A power-of-two length cannot be indexed out of range.
        if (HASH_LENGTH == (1 << IDX_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (in_index < IDX_W'(HASH_LENGTH));
        end
    endgenerate

    // Single shared adder: only one word lands per cycle.
    assign sum = prev_w[in_index] + data_f;

    always_comb begin
        hit = '0;
        if (in_range) hit[in_index] = 1'b1;
    end

    assign restart   = (state == S_IDLE || state == S_DONE) && start;
    assign capture   = (state == S_COLLECT) && in_valid && in_range;
    assign last_word = capture && (&(mask | hit));

`ifdef HASH_WRITEBACK_EN
    logic [IDX_W-1:0] cnt;
    logic             cnt_last;
    assign cnt_last = (cnt == IDX_W'(HASH_LENGTH - 1));
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_n = S_COLLECT;
`ifdef HASH_WRITEBACK_EN
            S_COLLECT:      if (last_word) state_n = S_WRITE;
            S_WRITE:        if (cnt_last) state_n = S_DONE;
`else
            S_COLLECT:      if (last_word) state_n = S_DONE;
`endif
            default:        state_n = S_IDLE;
        endcase
    end

    assign in_ready             = (state == S_COLLECT);
    assign hash_vector_complete = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            words       <= '0;
            mask        <= '0;
            index_error <= 1'b0;
        end else if (restart) begin
            words       <= '0;
            mask        <= '0;
            index_error <= 1'b0;
        end else if (state == S_COLLECT && in_valid) begin
            if (in_range) begin
                words[in_index] <= sum;
                mask            <= mask | hit;
            end else begin
                index_error     <= 1'b1;
            end
        end
    end

`ifdef HASH_WRITEBACK_EN
    always_ff @(posedge clock) begin
        if (reset)                 cnt <= '0;
        else if (state == S_WRITE) cnt <= cnt_last ? '0 : cnt + 1'b1;
    end

    // Outputs are gated so they read 0 outside the write burst.
    assign wr_en   = (state == S_WRITE);
    assign wr_addr = wr_en ? ADDR_WIDTH'(WRITE_BASE) + ADDR_WIDTH'(cnt) : '0;
    assign wr_data = wr_en ? words[cnt] : '0;
`else
    logic unused_base;
    assign unused_base = ^ADDR_WIDTH'(WRITE_BASE);
    assign wr_en   = 1'b0;
    assign wr_addr = '0;
    assign wr_data = '0;
`endif

endmodule

// File: tb/tb_hash_feedforward.sv
module tb_hash_feedforward;

  localparam int HL      = 8;
  localparam int WB_BASE = 'hFC;
`ifdef HASH_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic         start = 0, in_valid = 0;
  logic [2:0]   in_index = 0;
  logic [31:0]  in_data = 0;
  logic [255:0] prev_vec = 0;
  logic [255:0] hash_vec;
  logic         complete, ierr, in_ready, wr_en;
  logic [7:0]   wr_addr;
  logic [31:0]  wr_data;

  hash_feedforward #(.HASH_LENGTH(8), .WORD_WIDTH(32), .ADDR_WIDTH(8),
                     .WRITE_BASE(WB_BASE), .BIT_REVERSE(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_index(in_index), .in_data(in_data), .prev_hash_vector(prev_vec),
    .in_ready(in_ready), .hash_vector(hash_vec), .hash_vector_complete(complete),
    .index_error(ierr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  logic         start6 = 0, in_valid6 = 0;
  logic [2:0]   in_index6 = 0;
  logic [31:0]  in_data6 = 0;
  logic [191:0] prev6 = 0;
  logic [191:0] hash6;
  logic         complete6, ierr6, in_ready6, wr_en6;
  logic [7:0]   wr_addr6;
  logic [31:0]  wr_data6;

  hash_feedforward #(.HASH_LENGTH(6), .WORD_WIDTH(32), .ADDR_WIDTH(8),
                     .WRITE_BASE(0), .BIT_REVERSE(1'b1)) dut6 (
    .clock(clock), .reset(reset), .start(start6), .in_valid(in_valid6),
    .in_index(in_index6), .in_data(in_data6), .prev_hash_vector(prev6),
    .in_ready(in_ready6), .hash_vector(hash6), .hash_vector_complete(complete6),
    .index_error(ierr6), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6));

  logic [31:0] m_prev [HL];
  logic [31:0] m_words[HL];
  bit          m_mask [HL];
  bit          m_collect = 0;
  bit          m_done = 0;
  int          t0 = 0;

  function automatic logic [31:0] f(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  function automatic logic [255:0] m_vec();
    logic [255:0] v;
    for (int k = 0; k < HL; k++) v[k*32 +: 32] = m_words[k];
    return v;
  endfunction

  function automatic bit m_full();
    for (int k = 0; k < HL; k++) if (!m_mask[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_prev();
    for (int k = 0; k < HL; k++) prev_vec[k*32 +: 32] = m_prev[k];
  endtask

  task automatic model_clear();
    for (int k = 0; k < HL; k++) begin m_words[k] = '0; m_mask[k] = 0; end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_start();
    start = 1; t0 = cyc; step(); start = 0;
    model_clear(); m_collect = 1; m_done = 0;
    chk("start_ready", in_ready, 1'b1);
    chk("start_clear", hash_vec, 256'h0);
    chk("start_cmpl", complete, 1'b0);
    chk("start_ierr", ierr, 1'b0);
  endtask

  task automatic send(input int idx, input logic [31:0] d);
    in_valid = 1; in_index = 3'(idx); in_data = d;
    step();
    in_valid = 0;
    if (m_collect) begin
      m_words[idx] = add32(m_prev[idx], f(d));
      m_mask[idx]  = 1;
      if (m_full()) begin m_collect = 0; if (!WB) m_done = 1; end
    end
    chk("send_hash", hash_vec, m_vec());
    chk("send_ready", in_ready, m_collect);
    chk("send_cmpl", complete, m_done);
  endtask

  task automatic finish_run(input int exp_edges);
    logic [7:0] a;
    if (WB) begin
      for (int k = 0; k < HL; k++) begin
        a = 8'(WB_BASE + k);
        chk("wb_en", wr_en, 1'b1);
        chk("wb_addr", wr_addr, a);
        chk("wb_data", wr_data, m_words[k]);
        chk("wb_hold", hash_vec, m_vec());
        chk("wb_cmpl", complete, 1'b0);
        step();
      end
      m_done = 1;
    end
    chk("done_cmpl", complete, 1'b1);
    chk("done_wren", wr_en, 1'b0);
    chk("done_wraddr", wr_addr, 8'h0);
    chk("done_wrdata", wr_data, 32'h0);
    if (exp_edges > 0) chk("done_edges", cyc - t0, exp_edges);
    repeat (2) step();
    chk("done_hold", hash_vec, m_vec());
    chk("done_cmpl2", complete, 1'b1);
  endtask

  task automatic run_random();
    int n = 0;
    for (int k = 0; k < HL; k++) m_prev[k] = $urandom;
    set_prev();
    do_start();
    while (!m_full() && n < 200) begin
      n++;
      if ($urandom_range(0, 3) == 0) step();
      else send($urandom_range(0, HL - 1), $urandom);
    end
    chk("rand_full", m_full(), 1'b1);
    finish_run(0);
  endtask

  initial begin
    logic [255:0] hold;
    logic [31:0]  m6_prev[6], m6_words[6];
    logic [191:0] v6;
    int           seq6[7];
    int           n;

    repeat (2) step();
    chk("rst_hash", hash_vec, 256'h0);
    chk("rst_cmpl", complete, 1'b0);
    chk("rst_ierr", ierr, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_wren", wr_en, 1'b0);
    chk("rst_wraddr", wr_addr, 8'h0);
    chk("rst_wrdata", wr_data, 32'h0);
    reset = 0;
    step();

    for (int k = 0; k < HL; k++) m_prev[k] = 32'h6a09e667;
    set_prev();
    do_start();
    for (int k = 0; k < HL; k++) send(k, 32'h8000_0000);
    chk("a_const", hash_vec, {8{32'h6a09e668}});
    finish_run(WB ? 2 * HL + 1 : HL + 1);

    send(0, 32'h1234_5678);

    for (int k = 0; k < HL; k++) m_prev[k] = 32'hFFFF_FFFF;
    set_prev();
    do_start();
    for (int k = HL - 1; k >= 0; k--) send(k, 32'h4000_0000);
    chk("b_const", hash_vec, {8{32'h0000_0001}});
    finish_run(0);

    for (int k = 0; k < HL; k++) m_prev[k] = $urandom;
    m_prev[3] = 32'h1;
    set_prev();
    do_start();
    for (int k = 0; k < 3; k++) send(k, $urandom);
    send(3, 32'hA000_0000);
    hold = hash_vec;
    start = 1; step(); start = 0;
    chk("c_start_ign", hash_vec, hold);
    chk("c_start_rdy", in_ready, 1'b1);
    send(3, 32'h9000_0000);
    for (int k = 4; k < HL; k++) send(k, $urandom);
    chk("c_word3", hash_vec[3*32 +: 32], 32'h0000_000A);
    finish_run(0);

    start = 1; in_valid = 1; in_index = 3'd0; in_data = $urandom;
    step();
    start = 0; in_valid = 0;
    model_clear(); m_collect = 1; m_done = 0;
    chk("r_clear", hash_vec, 256'h0);
    chk("r_ready", in_ready, 1'b1);
    chk("r_cmpl", complete, 1'b0);
    for (int k = 0; k < HL; k++) send(k, $urandom);
    finish_run(0);

    do_start();
    for (int k = 0; k < 4; k++) send(k, $urandom);
    reset = 1; step();
    chk("mr_hash", hash_vec, 256'h0);
    chk("mr_ready", in_ready, 1'b0);
    chk("mr_cmpl", complete, 1'b0);
    chk("mr_wren", wr_en, 1'b0);
    chk("mr_wraddr", wr_addr, 8'h0);
    reset = 0;
    model_clear(); m_collect = 0; m_done = 0;
    send(2, $urandom);
    run_random();

    for (int r = 0; r < 4; r++) run_random();

    for (int k = 0; k < 6; k++) begin
      m6_prev[k] = $urandom; m6_words[k] = '0;
      prev6[k*32 +: 32] = m6_prev[k];
    end
    start6 = 1; step(); start6 = 0;
    chk("s6_ready", in_ready6, 1'b1);
    seq6 = '{0, 1, 2, 7, 3, 4, 5};
    foreach (seq6[i]) begin
      in_valid6 = 1; in_index6 = 3'(seq6[i]); in_data6 = $urandom;
      if (seq6[i] < 6) m6_words[seq6[i]] = add32(m6_prev[seq6[i]], f(in_data6));
      step();
      in_valid6 = 0;
      for (int k = 0; k < 6; k++) v6[k*32 +: 32] = m6_words[k];
      chk("s6_hash", hash6, v6);
      chk("s6_ierr", ierr6, (i >= 3) ? 1'b1 : 1'b0);
    end
    n = 0;
    while (!complete6 && n < 20) begin step(); n++; end
    chk("s6_cmpl", complete6, 1'b1);
    chk("s6_ierr_hold", ierr6, 1'b1);
    chk("s6_final", hash6, v6);
    start6 = 1; step(); start6 = 0;
    chk("s6_ierr_clr", ierr6, 1'b0);
    chk("s6_clr", hash6, 192'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
